pio_bank: RTL

PIO_BANK -- requirements
Module: pio_bank

---
 rtl/pio_bank_pkg.sv | 25 ++
 rtl/pio_debounce.sv | 89 ++++++++
 rtl/pio_bank.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pio_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pio_bank_pkg
//  Description : Shared register map and default channel direction mask for
//                the pio_bank parallel I/O block.
//  Revision    : 1.0 - initial release
// ============================================================================
package pio_bank_pkg;

    // Per-channel register index, taken from avs_address[1:0]
    typedef enum logic [1:0] {
        REG_DATA     = 2'd0,
        REG_IRQ_MASK = 2'd1,
        REG_EDGE_CAP = 2'd2,
        REG_RSVD     = 2'd3
    } pio_reg_e;

    // Upper bound on channel count; the direction mask is sized to it
    localparam int unsigned PIO_MAX_CH = 16;

    // Channels 0,1,2,5,6 are outputs; channels 3,4 are inputs
    localparam logic [PIO_MAX_CH-1:0] PIO_DIR_MASK_DEFAULT = 16'b0000_0000_0110_0111;

endpackage : pio_bank_pkg
`default_nettype wire

// File: rtl/pio_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : pio_debounce
//  Description : Two-flop synchronizer followed by a word-wide debouncer.
//                A new input word is accepted only once the synchronized value
//                has differed from the accepted value for DEB_CYCLES
//                consecutive cycles. With PIO_BANK_DEBOUNCE_EN undefined the
//                counter is omitted and the synchronized value is accepted
//                every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_debounce #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] stable_o,
    output logic [WIDTH-1:0] chg_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;

    // Two-flop synchronizer for the asynchronous pin word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef PIO_BANK_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive disagreeing cycles; accept the word on the last one
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce counter state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // No filtering: the synchronized word is accepted every cycle
    always_comb begin
        stable_d = sync2_q;
    end
`endif

    // Accepted (debounced) value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q <= '0;
        end else begin
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
    // Bits that flip on the coming edge; reset loads are never reported
    assign chg_o    = stable_d ^ stable_q;

endmodule : pio_debounce
`default_nettype wire

// File: rtl/pio_bank.sv
`default_nettype none
// ============================================================================
//  Module      : pio_bank
//  Description : Bank of N_CH parallel I/O channels behind an Avalon-MM slave.
//                Each channel owns four word registers {DATA, IRQ_MASK,
//                EDGE_CAP, reserved}. Output channels drive their DATA
//                register onto pio_out; input channels are synchronized,
//                debounced, edge-captured (W1C) and can raise a level irq.
//                Build option: PIO_BANK_DEBOUNCE_EN enables the debounce
//                counter inside pio_debounce.
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_bank
    import pio_bank_pkg::*;
#(
    parameter int unsigned              N_CH       = 7,
    parameter int unsigned              WIDTH      = 32,
    parameter logic [PIO_MAX_CH-1:0]    DIR_MASK   = PIO_DIR_MASK_DEFAULT,
    parameter int unsigned              DEB_CYCLES = 50000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(N_CH)+1:0]    avs_address,
    input  logic                       avs_read,
    input  logic                       avs_write,
    input  logic [31:0]                avs_writedata,
    output logic [31:0]                avs_readdata,
    input  logic [N_CH*WIDTH-1:0]      pio_in,
    output logic [N_CH*WIDTH-1:0]      pio_out,
    output logic                       irq
);

    logic [31:0]      w_ch;
    pio_reg_e         w_reg;
    logic [N_CH-1:0]  w_sel;
    logic [N_CH-1:0]  w_pend;
    logic [N_CH-1:0]  w_unused_in;
    logic [WIDTH-1:0] w_data [N_CH];
    logic [WIDTH-1:0] w_mask [N_CH];
    logic [WIDTH-1:0] w_ecap [N_CH];
    logic [31:0]      w_rd_val;
    logic [31:0]      readdata_q;
    logic             irq_q;

    // Address split: upper bits select the channel, low two the register
    assign w_ch  = 32'(avs_address >> 2);
    assign w_reg = pio_reg_e'(avs_address[1:0]);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Channel indices at or above N_CH never match, so they are unmapped
        assign w_sel[i] = (w_ch == i);

        if (DIR_MASK[i]) begin : g_out
            logic [WIDTH-1:0] data_q;

            // DATA register, which is also the pin driver
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_q <= '0;
                end else if (avs_write && w_sel[i] && (w_reg == REG_DATA)) begin
                    data_q <= avs_writedata[WIDTH-1:0];
                end
            end

            assign pio_out[i*WIDTH +: WIDTH] = data_q;
            assign w_data[i]      = data_q;
            assign w_mask[i]      = '0;
            assign w_ecap[i]      = '0;
            assign w_pend[i]      = 1'b0;
            assign w_unused_in[i] = |pio_in[i*WIDTH +: WIDTH];
        end else begin : g_in
            logic [WIDTH-1:0] stable;
            logic [WIDTH-1:0] chg;
            logic [WIDTH-1:0] mask_q;
            logic [WIDTH-1:0] ecap_q;
            logic [WIDTH-1:0] ecap_d;

            pio_debounce #(
                .WIDTH      (WIDTH),
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk      (clk),
                .reset    (reset),
                .din_i    (pio_in[i*WIDTH +: WIDTH]),
                .stable_o (stable),
                .chg_o    (chg)
            );

            // Interrupt mask register
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mask_q <= '0;
                end else if (avs_write && w_sel[i] && (w_reg == REG_IRQ_MASK)) begin
                    mask_q <= avs_writedata[WIDTH-1:0];
                end
            end

            // W1C clear first, then OR in new edges so a racing edge survives
            always_comb begin
                ecap_d = ecap_q;
                if (avs_write && w_sel[i] && (w_reg == REG_EDGE_CAP)) begin
                    ecap_d = ecap_q & ~avs_writedata[WIDTH-1:0];
                end
                ecap_d = ecap_d | chg;
            end

            // Sticky edge-capture register
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ecap_q <= '0;
                end else begin
                    ecap_q <= ecap_d;
                end
            end

            assign pio_out[i*WIDTH +: WIDTH] = '0;
            assign w_data[i]      = stable;
            assign w_mask[i]      = mask_q;
            assign w_ecap[i]      = ecap_q;
            assign w_pend[i]      = |(ecap_q & mask_q);
            assign w_unused_in[i] = 1'b0;
        end
    end

    // Read mux over current state, so a same-cycle write is not yet visible
    always_comb begin
        w_rd_val = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w_ch == 32'(c)) begin
                case (w_reg)
                    REG_DATA:     w_rd_val = 32'(w_data[c]);
                    REG_IRQ_MASK: w_rd_val = 32'(w_mask[c]);
                    REG_EDGE_CAP: w_rd_val = 32'(w_ecap[c]);
                    default:      w_rd_val = '0;
                endcase
            end
        end
    end

    // Fixed one-cycle read latency; the bus sees zero between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= avs_read ? w_rd_val : 32'd0;
        end
    end

    // Registered level interrupt from any enabled captured edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |w_pend;
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = irq_q;

endmodule : pio_bank
`default_nettype wire
